// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the multicycle signed divider: FSM state encoding,
// operand width, iteration count and iteration-counter width.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;
  // One restoring step retires one quotient bit, so iterations == width.
  localparam int DIV_ITER  = DIV_WIDTH;
  // Wide enough to hold DIV_ITER itself.
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step on unsigned magnitudes.
// The dividend sits in the quotient register and is shifted out MSB first
// while quotient bits are shifted in at the bottom.
// Ports:
//   rem_i  : partial remainder before this step
//   quo_i  : dividend/quotient shift register before this step
//   dvsr_i : unsigned divisor magnitude
//   rem_o  : partial remainder after this step
//   quo_o  : dividend/quotient shift register after this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH-1:0] rem_shift_s;
  logic [WIDTH:0]   diff_s;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    rem_shift_s = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
    // The extra bit is the borrow: set when rem_shift_s < dvsr_i.
    diff_s      = {1'b0, rem_shift_s} - {1'b0, dvsr_i};
    if (diff_s[WIDTH] == 1'b0) begin
      rem_o = diff_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_shift_s;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divisor.sv
// -----------------------------------------------------------------------------
// divisor
// Multicycle signed divider (MIPS DIV). Fixed latency: started in cycle 0,
// DivOut pulses in cycle 34. Truncating division: quotient rounds toward
// zero, remainder takes the dividend's sign.
// Ports:
//   clk        : system clock, rising edge
//   Reset      : synchronous active-high reset
//   A          : dividend (two's complement)
//   B          : divisor (two's complement)
//   DivIn      : start request, sampled only while idle
//   DivOut     : one-cycle done pulse, results valid in that cycle
//   DivZero    : one-cycle divide-by-zero pulse
//   resultHigh : remainder (to HI)
//   resultLow  : quotient (to LO)
// -----------------------------------------------------------------------------
module divisor
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             DivIn,
  output logic             DivOut,
  output logic             DivZero,
  output logic [WIDTH-1:0] resultHigh,
  output logic [WIDTH-1:0] resultLow
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITER - 1);

  div_state_t       state_q;
  logic [CNT_W-1:0] counter_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             div_out_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [WIDTH-1:0] res_lo_q;

  logic [WIDTH-1:0] abs_a_d;
  logic [WIDTH-1:0] abs_b_d;
  logic             b_zero_d;
  logic [WIDTH-1:0] step_rem_d;
  logic [WIDTH-1:0] step_quo_d;
  logic [WIDTH-1:0] fix_lo_d;
  logic [WIDTH-1:0] fix_hi_d;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    if (A[WIDTH-1] == 1'b1) begin
      abs_a_d = {WIDTH{1'b0}} - A;
    end else begin
      abs_a_d = A;
    end
    if (B[WIDTH-1] == 1'b1) begin
      abs_b_d = {WIDTH{1'b0}} - B;
    end else begin
      abs_b_d = B;
    end
    b_zero_d = (B == {WIDTH{1'b0}});
  end

  // Sign fix-up of the unsigned quotient and remainder.
  always_comb begin
    if (qneg_q == 1'b1) begin
      fix_lo_d = {WIDTH{1'b0}} - quo_q;
    end else begin
      fix_lo_d = quo_q;
    end
    if (rneg_q == 1'b1) begin
      fix_hi_d = {WIDTH{1'b0}} - rem_q;
    end else begin
      fix_hi_d = rem_q;
    end
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem_d),
    .quo_o  (step_quo_d)
  );

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      counter_q  <= {CNT_W{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      quo_q      <= {WIDTH{1'b0}};
      dvsr_q     <= {WIDTH{1'b0}};
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      div_out_q  <= 1'b0;
      div_zero_q <= 1'b0;
      res_hi_q   <= {WIDTH{1'b0}};
      res_lo_q   <= {WIDTH{1'b0}};
    end else begin
      // Both status outputs are single-cycle pulses unless re-asserted below.
      div_out_q  <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (DivIn && !b_zero_d) begin
            quo_q     <= abs_a_d;
            dvsr_q    <= abs_b_d;
            qneg_q    <= A[WIDTH-1] ^ B[WIDTH-1];
            rneg_q    <= A[WIDTH-1];
            rem_q     <= {WIDTH{1'b0}};
            counter_q <= {CNT_W{1'b0}};
            state_q   <= CALC;
          end else if (DivIn) begin
            // Divide by zero: flag it, leave results untouched, stay idle.
            div_zero_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          rem_q     <= step_rem_d;
          quo_q     <= step_quo_d;
          counter_q <= counter_q + CNT_W'(1);
          if (counter_q == LAST_STEP) begin
            state_q <= SIGN;
          end else begin
            state_q <= CALC;
          end
        end
        SIGN: begin
          res_lo_q  <= fix_lo_d;
          res_hi_q  <= fix_hi_d;
          div_out_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          // DivOut was raised on entry; it drops on the way back to IDLE.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DivOut     = div_out_q;
  assign DivZero    = div_zero_q;
  assign resultHigh = res_hi_q;
  assign resultLow  = res_lo_q;

endmodule

// File: tb/tb_divisor.sv
// -----------------------------------------------------------------------------
// tb_divisor
// Directed-vector bench for the divisor block. Cycle n is the cycle that
// follows the n-th rising edge after the start cycle; inputs change and
// outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_divisor;

  logic        clk;
  logic        Reset;
  logic [31:0] A;
  logic [31:0] B;
  logic        DivIn;
  logic        DivOut;
  logic        DivZero;
  logic [31:0] resultHigh;
  logic [31:0] resultLow;

  int checks;
  int passed;

  divisor dut (
    .clk        (clk),
    .Reset      (Reset),
    .A          (A),
    .B          (B),
    .DivIn      (DivIn),
    .DivOut     (DivOut),
    .DivZero    (DivZero),
    .resultHigh (resultHigh),
    .resultLow  (resultLow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one division in the current cycle (cycle 0) and observes 40 cycles.
  // Operands are scrambled after the start cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int done_cyc, output int pulses,
                        output int zero_cyc, output int zeros,
                        output logic [31:0] lo, output logic [31:0] hi);
    done_cyc = -1;
    pulses   = 0;
    zero_cyc = -1;
    zeros    = 0;
    lo       = 32'h0;
    hi       = 32'h0;
    A = a;
    B = b;
    DivIn = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) begin
        DivIn = 1'b0;
        A = 32'hDEAD_BEEF;
        B = 32'h0000_0003;
      end
      if (DivOut === 1'b1) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = n;
          lo = resultLow;
          hi = resultHigh;
        end
      end
      if (DivZero === 1'b1) begin
        zeros++;
        if (zero_cyc < 0) zero_cyc = n;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    DivIn = 1'b0;
    A = 32'h0;
    B = 32'h0;
    tick();
    tick();
    Reset = 1'b0;
    checks++; if (DivOut !== 1'b0) $display("FAIL reset_divout got %0b want 0", DivOut); else passed++;
    checks++; if (DivZero !== 1'b0) $display("FAIL reset_divzero got %0b want 0", DivZero); else passed++;
    checks++; if (resultHigh !== 32'h0) $display("FAIL reset_hi got %h want 00000000", resultHigh); else passed++;
    checks++; if (resultLow !== 32'h0) $display("FAIL reset_lo got %h want 00000000", resultLow); else passed++;
  endtask

  task automatic test_basic();
    int dc, pc, zc, zn;
    logic [31:0] lo, hi;
    run_op(32'd7, 32'd2, dc, pc, zc, zn, lo, hi);
    checks++; if (dc !== 34) $display("FAIL basic_latency got %0d want 34", dc); else passed++;
    checks++; if (pc !== 1) $display("FAIL basic_pulses got %0d want 1", pc); else passed++;
    checks++; if (zn !== 0) $display("FAIL basic_divzero got %0d want 0", zn); else passed++;
    checks++; if (lo !== 32'd3) $display("FAIL basic_lo got %h want 00000003", lo); else passed++;
    checks++; if (hi !== 32'd1) $display("FAIL basic_hi got %h want 00000001", hi); else passed++;
    checks++; if (resultLow !== 32'd3) $display("FAIL basic_hold_lo got %h want 00000003", resultLow); else passed++;
  endtask

  task automatic test_signed();
    int dc, pc, zc, zn;
    logic [31:0] lo, hi;
    run_op(32'hFFFF_FFF9, 32'd2, dc, pc, zc, zn, lo, hi);
    checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL neg_dividend_lo got %h want fffffffd", lo); else passed++;
    checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL neg_dividend_hi got %h want ffffffff", hi); else passed++;
    run_op(32'd7, 32'hFFFF_FFFE, dc, pc, zc, zn, lo, hi);
    checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL neg_divisor_lo got %h want fffffffd", lo); else passed++;
    checks++; if (hi !== 32'd1) $display("FAIL neg_divisor_hi got %h want 00000001", hi); else passed++;
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, dc, pc, zc, zn, lo, hi);
    checks++; if (lo !== 32'd3) $display("FAIL neg_both_lo got %h want 00000003", lo); else passed++;
    checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL neg_both_hi got %h want ffffffff", hi); else passed++;
    run_op(32'd100, 32'd7, dc, pc, zc, zn, lo, hi);
    checks++; if (lo !== 32'd14) $display("FAIL pos_100_7_lo got %h want 0000000e", lo); else passed++;
    checks++; if (hi !== 32'd2) $display("FAIL pos_100_7_hi got %h want 00000002", hi); else passed++;
  endtask

  task automatic test_divzero();
    int dc, pc, zc, zn;
    logic [31:0] lo, hi;
    // Establish the prior result 3 r 1.
    run_op(32'd7, 32'd2, dc, pc, zc, zn, lo, hi);
    run_op(32'd5, 32'd0, dc, pc, zc, zn, lo, hi);
    checks++; if (zc !== 1) $display("FAIL divzero_cycle got %0d want 1", zc); else passed++;
    checks++; if (zn !== 1) $display("FAIL divzero_pulses got %0d want 1", zn); else passed++;
    checks++; if (pc !== 0) $display("FAIL divzero_divout got %0d want 0", pc); else passed++;
    checks++; if (resultLow !== 32'd3) $display("FAIL divzero_keep_lo got %h want 00000003", resultLow); else passed++;
    checks++; if (resultHigh !== 32'd1) $display("FAIL divzero_keep_hi got %h want 00000001", resultHigh); else passed++;
  endtask

  task automatic test_overflow();
    int dc, pc, zc, zn;
    logic [31:0] lo, hi;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, dc, pc, zc, zn, lo, hi);
    checks++; if (dc !== 34) $display("FAIL ovf_latency got %0d want 34", dc); else passed++;
    checks++; if (zn !== 0) $display("FAIL ovf_divzero got %0d want 0", zn); else passed++;
    checks++; if (lo !== 32'h8000_0000) $display("FAIL ovf_lo got %h want 80000000", lo); else passed++;
    checks++; if (hi !== 32'h0) $display("FAIL ovf_hi got %h want 00000000", hi); else passed++;
    run_op(32'h8000_0000, 32'd1, dc, pc, zc, zn, lo, hi);
    checks++; if (lo !== 32'h8000_0000) $display("FAIL minint_by_1_lo got %h want 80000000", lo); else passed++;
    checks++; if (hi !== 32'h0) $display("FAIL minint_by_1_hi got %h want 00000000", hi); else passed++;
  endtask

  task automatic test_back_to_back();
    int first_done, second_done, pulses;
    logic [31:0] lo1, hi1, lo2, hi2;
    first_done = -1;
    second_done = -1;
    pulses = 0;
    lo1 = 32'h0; hi1 = 32'h0; lo2 = 32'h0; hi2 = 32'h0;
    A = 32'd100;
    B = 32'd7;
    DivIn = 1'b1;
    for (int n = 1; n <= 75; n++) begin
      tick();
      DivIn = 1'b0;
      if (n == 5) begin
        A = 32'd1;
        B = 32'd1;
        DivIn = 1'b1;
      end
      if (DivOut === 1'b1) begin
        pulses++;
        if (first_done < 0) begin
          first_done = n; lo1 = resultLow; hi1 = resultHigh;
        end else if (second_done < 0) begin
          second_done = n; lo2 = resultLow; hi2 = resultHigh;
        end
      end
      // Raise DivIn in DONE and hold it into the following idle cycle.
      if (n == 34 || n == 35) begin
        A = 32'd20;
        B = 32'd3;
        DivIn = 1'b1;
      end
    end
    DivIn = 1'b0;
    checks++; if (first_done !== 34) $display("FAIL b2b_first_latency got %0d want 34", first_done); else passed++;
    checks++; if (lo1 !== 32'd14) $display("FAIL b2b_first_lo got %h want 0000000e", lo1); else passed++;
    checks++; if (hi1 !== 32'd2) $display("FAIL b2b_first_hi got %h want 00000002", hi1); else passed++;
    checks++; if (second_done !== 69) $display("FAIL b2b_second_latency got %0d want 69", second_done); else passed++;
    checks++; if (lo2 !== 32'd6) $display("FAIL b2b_second_lo got %h want 00000006", lo2); else passed++;
    checks++; if (hi2 !== 32'd2) $display("FAIL b2b_second_hi got %h want 00000002", hi2); else passed++;
    checks++; if (pulses !== 2) $display("FAIL b2b_pulses got %0d want 2", pulses); else passed++;
  endtask

  task automatic test_reset_abort();
    int dc, pc, zc, zn, late_pulses;
    logic [31:0] lo, hi;
    logic [31:0] lo_r, hi_r;
    logic        out_r, zero_r;
    late_pulses = 0;
    lo_r = 32'hFFFF_FFFF; hi_r = 32'hFFFF_FFFF; out_r = 1'b1; zero_r = 1'b1;
    A = 32'd100;
    B = 32'd7;
    DivIn = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      DivIn = 1'b0;
      Reset = 1'b0;
      if (n == 11) begin
        lo_r = resultLow; hi_r = resultHigh; out_r = DivOut; zero_r = DivZero;
      end
      if (DivOut === 1'b1) late_pulses++;
      if (n == 10) Reset = 1'b1;
    end
    checks++; if (lo_r !== 32'h0) $display("FAIL abort_lo got %h want 00000000", lo_r); else passed++;
    checks++; if (hi_r !== 32'h0) $display("FAIL abort_hi got %h want 00000000", hi_r); else passed++;
    checks++; if (out_r !== 1'b0) $display("FAIL abort_divout got %0b want 0", out_r); else passed++;
    checks++; if (zero_r !== 1'b0) $display("FAIL abort_divzero got %0b want 0", zero_r); else passed++;
    checks++; if (late_pulses !== 0) $display("FAIL abort_no_done got %0d want 0", late_pulses); else passed++;
    run_op(32'd100, 32'd7, dc, pc, zc, zn, lo, hi);
    checks++; if (dc !== 34) $display("FAIL restart_latency got %0d want 34", dc); else passed++;
    checks++; if (lo !== 32'd14) $display("FAIL restart_lo got %h want 0000000e", lo); else passed++;
    checks++; if (hi !== 32'd2) $display("FAIL restart_hi got %h want 00000002", hi); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    Reset = 1'b1;
    DivIn = 1'b0;
    A = 32'h0;
    B = 32'h0;
    test_reset();
    test_basic();
    test_signed();
    test_divzero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
